// File: rtl/adc_capture_if.sv
// Pin and sample bundle between the LTC2308 capture controller and its neighbours.
// The master side is the controller: it drives the ADC strobes and the held sample.
interface adc_capture_if;
  logic        enable;
  logic        adc_convst;
  logic        adc_sclk;
  logic        adc_din;
  logic        adc_dout;
  logic [11:0] data;
  logic        data_valid;
  logic        busy;

  modport master (
    input  enable, adc_dout,
    output adc_convst, adc_sclk, adc_din, data, data_valid, busy
  );

  modport slave (
    output enable, adc_dout,
    input  adc_convst, adc_sclk, adc_din, data, data_valid, busy
  );
endinterface

// File: rtl/adc_capture.sv
// Free-running LTC2308 controller: CONVST pulse, conversion wait, 12-bit SPI frame,
// then a held sample with a one-cycle valid strobe. All outputs come straight from flops.
module adc_capture #(
  parameter int         CLK_DIV     = 2,
  parameter int         CONV_CYCLES = 80,
  parameter logic [2:0] CHANNEL     = 3'd0,
  parameter logic       UNIPOLAR    = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  adc_capture_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_WAIT,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int CNT_MAX = (CONV_CYCLES > 2 * CLK_DIV) ? CONV_CYCLES : 2 * CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Serial DIN sequence, first bit in [11]: {S/D, O/S, S1, S0, UNI, SLP} then six zeros.
  localparam logic [11:0] DIN_SEQ = {1'b1, CHANNEL[0], CHANNEL[2], CHANNEL[1],
                                     UNIPOLAR, 1'b0, 6'b000000};

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [3:0]         bit_reg;
  logic [11:0]        shift_reg;
  logic               first_frame_reg;
  logic               convst_reg;
  logic               sclk_reg;
  logic               din_reg;
  logic [11:0]        data_reg;
  logic               data_valid_reg;
  logic               busy_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      bit_reg         <= '0;
      shift_reg       <= '0;
      first_frame_reg <= 1'b1;
      convst_reg      <= 1'b0;
      sclk_reg        <= 1'b0;
      din_reg         <= 1'b0;
      data_reg        <= 12'h000;
      data_valid_reg  <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (bus.enable) begin
            state_reg  <= ST_CONV;
            convst_reg <= 1'b1;
            busy_reg   <= 1'b1;
            cnt_reg    <= '0;
          end
        end
        ST_CONV: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_reg  <= ST_WAIT;
            convst_reg <= 1'b0;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (cnt_reg == CNT_W'(CONV_CYCLES - 1)) begin
            state_reg <= ST_SHIFT;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            din_reg   <= DIN_SEQ[11];
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          // cnt_reg is the phase within one SCLK period: low half first, then high half.
          if (cnt_reg == CNT_W'(2 * CLK_DIV - 1)) begin
            sclk_reg <= 1'b0;
            cnt_reg  <= '0;
            if (bit_reg == 4'd11) begin
              state_reg <= ST_DONE;
              din_reg   <= 1'b0;
            end else begin
              bit_reg <= bit_reg + 4'd1;
              din_reg <= DIN_SEQ[4'd10 - bit_reg];
            end
          end else begin
            if (cnt_reg == CNT_W'(CLK_DIV - 1)) begin
              sclk_reg  <= 1'b1;
              shift_reg <= {shift_reg[10:0], bus.adc_dout};
            end
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // The ADC applies a config word one frame late, so the first result is stale.
          if (!first_frame_reg) begin
            data_reg       <= shift_reg;
            data_valid_reg <= 1'b1;
          end
          first_frame_reg <= 1'b0;
          cnt_reg         <= '0;
          if (bus.enable) begin
            state_reg  <= ST_CONV;
            convst_reg <= 1'b1;
          end else begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.adc_convst = convst_reg;
  assign bus.adc_sclk   = sclk_reg;
  assign bus.adc_din    = din_reg;
  assign bus.data       = data_reg;
  assign bus.data_valid = data_valid_reg;
  assign bus.busy       = busy_reg;

endmodule
